// File: rtl/window_apply_pkg.sv
// window_apply_pkg: shared window-type codes, Q8 constants, FSM states and lgn clamp
package window_apply_pkg;

    localparam logic [3:0] WT_RECT  = 4'd1;
    localparam logic [3:0] WT_TUKEY = 4'd2;
    localparam logic [3:0] WT_TRI   = 4'd3;
    localparam logic [3:0] WT_HANN  = 4'd4;
    localparam logic [3:0] WT_HAMM  = 4'd5;
    localparam logic [3:0] WT_BLACK = 4'd6;

    localparam int Q8_ONE = 256;

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_MUL, ST_OUT} state_t;

    function automatic logic [7:0] clamp_lgn(input logic [7:0] l);
        return (l == 8'd0) ? 8'd1 : (l > 8'd15) ? 8'd15 : l;
    endfunction

endpackage

// File: rtl/window_apply_q8_mul_sat.sv
// q8_mul_sat: registered signed sample x Q8 coefficient with round-half-up and saturation
module q8_mul_sat
    import window_apply_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [DW-1:0] i_a,
    input  logic [15:0]   i_b,
    output logic [DW-1:0] o_y
);

    localparam int PW = DW + 17;
    localparam int SH = $clog2(Q8_ONE);

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_rnd;
    logic signed [PW-1:0] w_max;
    logic signed [PW-1:0] w_min;
    logic [DW-1:0]        w_sat;

    // one guard bit above the full product keeps the rounding add from wrapping
    assign w_prod = PW'($signed(i_a)) * PW'($signed(i_b));
    assign w_rnd  = (w_prod + PW'(Q8_ONE / 2)) >>> SH;
    assign w_max  = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    assign w_min  = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    assign w_sat  = (w_rnd > w_max) ? {1'b0, {(DW-1){1'b1}}} :
                    (w_rnd < w_min) ? {1'b1, {(DW-1){1'b0}}} : w_rnd[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_y <= '0;
        else if (i_en)
            o_y <= w_sat;
    end

endmodule

// File: rtl/window_apply.sv
// window_apply: per-sample sequencing of the window generator, Q8 multiply and output handshake.
// Generator timeouts emit a zero sample and raise a sticky err so the stream never stalls.
module window_apply
    import window_apply_pkg::*;
#(
    parameter int DW  = 16,
    parameter int TMO = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic [3:0]    win_type,
    input  logic [7:0]    lgn,
    input  logic          restart,
    output logic          gen_en,
    output logic [3:0]    gen_win_type,
    output logic [15:0]   gen_n,
    output logic [15:0]   gen_i,
    output logic [7:0]    gen_lgn,
    input  logic          gen_busy,
    input  logic [15:0]   gen_win,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          err
);

    localparam int TW = $clog2(TMO + 1);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_s;
    logic [15:0]   r_win;
    logic [15:0]   r_idx;
    logic [7:0]    r_lgn;
    logic [3:0]    r_wt;
    logic [TW-1:0] r_tmo;
    logic          r_err;
    logic          r_pend;
    logic          w_acc;
    logic          w_tmo;
    logic          w_last;
    logic          w_hs;
    logic          w_first;

    assign w_acc   = (r_state == ST_IDLE) && s_valid;
    assign w_tmo   = ((r_state == ST_REQ) || (r_state == ST_WAIT)) && (r_tmo == TW'(TMO - 1));
    assign w_last  = (r_idx == gen_n - 16'd1);
    assign w_hs    = (r_state == ST_OUT) && m_ready;
    assign w_first = (r_idx == 16'd0) || restart;

    assign gen_win_type = r_wt;
    assign gen_lgn      = r_lgn;
    assign gen_n        = 16'd1 << r_lgn;
    assign gen_i        = r_idx;
    assign err          = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = s_valid ? ST_REQ : ST_IDLE;
            ST_REQ:  w_next = w_tmo ? ST_MUL : gen_busy ? ST_WAIT : ST_REQ;
            ST_WAIT: w_next = (w_tmo || !gen_busy) ? ST_MUL : ST_WAIT;
            ST_MUL:  w_next = ST_OUT;
            ST_OUT:  w_next = m_ready ? ST_IDLE : ST_OUT;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = (r_state == ST_IDLE);
        gen_en  = (r_state == ST_REQ) && !w_tmo;
        m_valid = (r_state == ST_OUT);
        m_last  = (r_state == ST_OUT) && w_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_win  <= '0;
            r_idx  <= '0;
            r_lgn  <= 8'd1;
            r_wt   <= WT_RECT;
            r_tmo  <= '0;
            r_err  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            // counter restarts on the REQ->WAIT transition, so each phase gets TMO cycles
            r_tmo <= (((r_state == ST_REQ) && !gen_busy) || ((r_state == ST_WAIT) && gen_busy)) ? r_tmo + TW'(1) : '0;
            if (w_acc) begin
                r_s <= s_data;
                if (w_first) begin
                    r_wt  <= win_type;
                    r_lgn <= clamp_lgn(lgn);
                end
            end
            if ((r_state == ST_WAIT) && !gen_busy)
                r_win <= gen_win;
            if (w_tmo) begin
                r_win <= '0;
                r_err <= 1'b1;
            end
            if ((r_state == ST_IDLE) && restart)
                r_idx <= '0;
            else if (w_hs)
                r_idx <= (r_pend || restart || w_last) ? 16'd0 : r_idx + 16'd1;
            r_pend <= ((r_state == ST_IDLE) || w_hs) ? 1'b0 : (r_pend | restart);
        end
    end

    q8_mul_sat #(.DW(DW)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (r_state == ST_MUL),
        .i_a   (r_s),
        .i_b   (r_win),
        .o_y   (m_data)
    );

endmodule

// File: tb/tb_window_apply.sv
// tb_window_apply: directed scoreboard bench with a small behavioural window generator
module tb_window_apply;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        s_valid = 0;
    logic        s_ready;
    logic [15:0] s_data = 0;
    logic [3:0]  win_type = 4'd1;
    logic [7:0]  lgn = 8'd2;
    logic        restart = 0;
    logic        gen_en;
    logic [3:0]  gen_win_type;
    logic [15:0] gen_n;
    logic [15:0] gen_i;
    logic [7:0]  gen_lgn;
    logic        gen_busy = 0;
    logic [15:0] gen_win;
    logic        m_valid;
    logic        m_ready = 0;
    logic [15:0] m_data;
    logic        m_last;
    logic        err;

    logic [15:0] g_coef = 16'd256;
    bit          g_never = 0;
    logic        g_prev = 0;
    int          g_cnt = 0;

    typedef struct packed {logic last; logic [15:0] data;} exp_t;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    assign gen_win = g_coef;

    always #5 clk = ~clk;

    window_apply #(.DW(16), .TMO(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .win_type(win_type), .lgn(lgn), .restart(restart), .gen_en(gen_en),
        .gen_win_type(gen_win_type), .gen_n(gen_n), .gen_i(gen_i), .gen_lgn(gen_lgn),
        .gen_busy(gen_busy), .gen_win(gen_win), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .err(err)
    );

    // generator model: rising gen_en starts a short delay, then busy for a few cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_prev   <= 0;
            g_cnt    <= 0;
            gen_busy <= 0;
        end else begin
            g_prev   <= gen_en;
            gen_busy <= (g_cnt >= 2) && (g_cnt <= 5);
            if (g_cnt != 0)
                g_cnt <= g_cnt - 1;
            else if (gen_en && !g_prev && !g_never)
                g_cnt <= 7;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic [15:0] ed, input logic el,
                        input int ei, input int hold, input bit rs);
        exp_t e;
        int t;
        m_ready = 0;
        @(negedge clk);
        s_data  = d;
        s_valid = 1;
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        sb.push_back({el, ed});
        @(posedge clk);
        #1 s_valid = 0;
        @(negedge clk);
        chk("gen_i", 32'(gen_i), ei);
        if (rs) begin
            restart = 1;
            @(negedge clk);
            restart = 0;
        end
        t = 0;
        while (!m_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("m_valid", 32'(m_valid), 1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        chk("m_data", $signed(m_data), $signed(e.data));
        chk("m_last", 32'(m_last), 32'(e.last));
        repeat (hold) begin
            @(negedge clk);
            chk("hold_data", $signed(m_data), $signed(e.data));
            chk("hold_s_ready", 32'(s_ready), 0);
        end
        m_ready = 1;
        @(negedge clk);
        m_ready = 0;
        chk("m_valid_drop", 32'(m_valid), 0);
    endtask

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_gen_en", 32'(gen_en), 0);
        chk("rst_gen_i", 32'(gen_i), 0);
        chk("rst_gen_n", 32'(gen_n), 2);
        chk("rst_gen_lgn", 32'(gen_lgn), 1);
        chk("rst_gen_wt", 32'(gen_win_type), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1;

        // rectangle, lgn=2
        send(16'd100, 16'd100, 0, 0, 0, 0);
        chk("rect_n", 32'(gen_n), 4);
        send(-16'sd100, -16'sd100, 0, 1, 0, 0);
        send(16'h7FFF, 16'h7FFF, 0, 2, 0, 0);
        send(16'h8000, 16'h8000, 1, 3, 0, 0);
        chk("wrap_idx", 32'(gen_i), 0);

        // Hann stub, coefficient 0.5
        win_type = 4'd4;
        g_coef   = 16'd128;
        send(16'd1000, 16'd500, 0, 0, 0, 0);
        chk("hann_wt", 32'(gen_win_type), 4);
        send(-16'sd1000, -16'sd500, 0, 1, 0, 0);
        send(16'd3, 16'd2, 0, 2, 0, 0);

        // saturation, coefficient 300/256
        g_coef = 16'd300;
        send(16'h7FFF, 16'h7FFF, 1, 3, 0, 0);
        send(16'h8000, 16'h8000, 0, 0, 0, 0);

        // timeout: generator never goes busy
        g_never = 1;
        send(16'd555, 16'd0, 0, 1, 0, 0);
        chk("err_set", 32'(err), 1);
        g_never = 0;
        g_coef  = 16'd256;
        send(16'd7, 16'd7, 0, 2, 0, 0);
        chk("err_sticky", 32'(err), 1);

        // backpressure
        send(16'd200, 16'd200, 1, 3, 10, 0);

        // restart mid-frame with a new lgn
        send(16'd10, 16'd10, 0, 0, 0, 0);
        send(16'd11, 16'd11, 0, 1, 0, 0);
        lgn = 8'd3;
        send(16'd12, 16'd12, 0, 2, 0, 1);
        chk("midframe_lgn", 32'(gen_lgn), 2);
        send(16'd13, 16'd13, 0, 0, 0, 0);
        chk("restart_lgn", 32'(gen_lgn), 3);
        chk("restart_n", 32'(gen_n), 8);

        // reset while in WAIT
        @(negedge clk);
        s_data  = 16'd99;
        s_valid = 1;
        @(posedge clk);
        #1 s_valid = 0;
        t = 0;
        while (!gen_busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("busy_seen", 32'(gen_busy), 1);
        @(negedge clk);
        chk("wait_gen_en", 32'(gen_en), 0);
        rst_n = 0;
        #1;
        chk("arst_s_ready", 32'(s_ready), 1);
        chk("arst_m_valid", 32'(m_valid), 0);
        chk("arst_gen_i", 32'(gen_i), 0);
        chk("arst_gen_n", 32'(gen_n), 2);
        chk("arst_gen_lgn", 32'(gen_lgn), 1);
        chk("arst_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        chk("arst_hold_valid", 32'(m_valid), 0);
        rst_n = 1;

        // lgn=0 clamps to 1: two-sample frame
        lgn = 8'd0;
        send(16'd42, 16'd42, 0, 0, 0, 0);
        chk("clamp_lgn", 32'(gen_lgn), 1);
        send(-16'sd5, -16'sd5, 1, 1, 0, 0);
        chk("clamp_wrap", 32'(gen_i), 0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
